// File: rtl/pll_lock_supervisor.sv
// Purpose: sequences the PLL reset, qualifies lock, and gates the system reset on stable lock.
// Latency: sys_rst_n rises LOCK_STABLE_CYCLES+2 edges after lock is first sampled; falls <=3 edges after lock loss.
// Backpressure: none; force_relock is a single-cycle request honoured in any state.
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 20
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       lock_ok,
  output logic       fail,
  output logic [3:0] retry_count,
  output logic [7:0] lol_count
);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAIL
  } state_t;

  // Terminal counts: a phase of N cycles ends when the counter shows N-1.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             locked_m;
  logic             locked_s;

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= pll_locked;
      locked_s <= locked_m;
    end
  end

  // Sequencing FSM; outputs are registered and move on the same edge as the state.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state       <= S_RESET_PLL;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      sys_rst_n   <= 1'b0;
      lock_ok     <= 1'b0;
      fail        <= 1'b0;
      retry_count <= 4'd0;
      lol_count   <= 8'd0;
    end else if (force_relock) begin
      // Restart wins over every other transition, and is not a loss-of-lock event.
      state       <= S_RESET_PLL;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      sys_rst_n   <= 1'b0;
      lock_ok     <= 1'b0;
      fail        <= 1'b0;
      retry_count <= 4'd0;
    end else begin
      case (state)
        S_RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state   <= S_WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          // Lock beats a coincident timeout.
          if (locked_s) begin
            state <= S_STABILIZE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt     <= '0;
            pll_rst <= 1'b1;
            if (retry_count == RETRY_LIMIT) begin
              state <= S_FAIL;
              fail  <= 1'b1;
            end else begin
              state       <= S_RESET_PLL;
              retry_count <= retry_count + 4'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STABILIZE: begin
          // A lock dropout sends us back to waiting with a fresh timeout, no retry charged.
          if (!locked_s) begin
            state <= S_WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state       <= S_RUN;
            cnt         <= '0;
            sys_rst_n   <= 1'b1;
            lock_ok     <= 1'b1;
            retry_count <= 4'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state     <= S_RESET_PLL;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            lock_ok   <= 1'b0;
            if (lol_count != 8'hFF) begin
              lol_count <= lol_count + 8'd1;
            end
          end
        end
        S_FAIL: begin
          // Parked with the PLL held in reset until force_relock or rst_n.
          pll_rst <= 1'b1;
        end
        default: begin
          state     <= S_RESET_PLL;
          cnt       <= '0;
          pll_rst   <= 1'b1;
          sys_rst_n <= 1'b0;
          lock_ok   <= 1'b0;
          fail      <= 1'b0;
        end
      endcase
    end
  end

endmodule
